// File: rtl/display_scheduler_pkg.sv
// rtl/display_scheduler_pkg.sv - shared types and constants for the display scheduler
package display_scheduler_pkg;

  typedef enum logic [1:0] {
    NORMAL,
    LOW,
    EXPIRED
  } mode_t;

  localparam int unsigned LOW_THRESH_DEFAULT = 180;
  localparam logic [6:0]  SEG_BLANK          = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - active-low 7-segment decode, segment a in bit6 through g in bit0
module bcd_to_seg
  import display_scheduler_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - four-digit scan multiplexer with meter-time blink modes
module display_scheduler
  import display_scheduler_pkg::*;
#(
  parameter int unsigned LOW_THRESH = LOW_THRESH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_scan,
  input  logic        tick_half,
  input  logic [13:0] time_left,
  input  logic [3:0]  val1,
  input  logic [3:0]  val2,
  input  logic [3:0]  val3,
  input  logic [3:0]  val4,
  output logic [6:0]  led_seg,
  output logic        a1,
  output logic        a2,
  output logic        a3,
  output logic        a4
);

  localparam logic [13:0] THRESH = 14'(LOW_THRESH);

  mode_t      mode_q, mode_d, mode_cls;
  logic       phase_q, phase_d;
  logic       half_cnt_q, half_cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] digit;
  logic [6:0] seg_dec;
  logic [3:0] anode_q;

  always_comb begin
    if (time_left == 14'd0)       mode_cls = EXPIRED;
    else if (time_left < THRESH)  mode_cls = LOW;
    else                          mode_cls = NORMAL;
  end

  // A mode change restarts the blink cycle lit and wins over a coincident half tick.
  always_comb begin
    mode_d     = mode_cls;
    phase_d    = phase_q;
    half_cnt_d = half_cnt_q;
    idx_d      = tick_scan ? idx_q + 2'd1 : idx_q;
    if (mode_cls != mode_q) begin
      phase_d    = 1'b1;
      half_cnt_d = 1'b0;
    end else begin
      case (mode_q)
        LOW: begin
          if (tick_half) begin
            if (half_cnt_q) begin
              phase_d    = ~phase_q;
              half_cnt_d = 1'b0;
            end else begin
              half_cnt_d = 1'b1;
            end
          end
        end
        EXPIRED: begin
          if (tick_half) phase_d = ~phase_q;
        end
        default: begin
          phase_d    = 1'b1;
          half_cnt_d = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    case (idx_d)
      2'd0:    digit = val1;
      2'd1:    digit = val2;
      2'd2:    digit = val3;
      default: digit = val4;
    endcase
  end

  bcd_to_seg u_dec (
    .bcd (digit),
    .seg (seg_dec)
  );

  // Outputs are built from next-state index and phase so anode and pattern move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= NORMAL;
      phase_q    <= 1'b1;
      half_cnt_q <= 1'b0;
      idx_q      <= 2'd0;
      anode_q    <= 4'hF;
      led_seg    <= SEG_BLANK;
    end else begin
      mode_q     <= mode_d;
      phase_q    <= phase_d;
      half_cnt_q <= half_cnt_d;
      idx_q      <= idx_d;
      if (phase_d) begin
        anode_q <= ~(4'b0001 << idx_d);
        led_seg <= seg_dec;
      end else begin
        anode_q <= 4'hF;
        led_seg <= SEG_BLANK;
      end
    end
  end

  assign {a4, a3, a2, a1} = anode_q;

endmodule
